// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I type definitions, plus the EX/MEM stage state and payload types.
package riscv_32i_defs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } ex_mem_state_e;

  // 39-bit entry carried through the EX/MEM skid buffer.
  typedef struct packed {
    word_t     result;
    logic      zero;
    reg_addr_t rd;
    logic      reg_write;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer (head + skid register) with flush,
// registered in_ready, and x0 write suppression at capture.
module ex_mem_stage
  import riscv_32i_defs_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      in_valid,
  output logic      in_ready,
  input  word_t     in_result,
  input  logic      in_zero,
  input  reg_addr_t in_rd,
  input  logic      in_reg_write,
  output logic      out_valid,
  input  logic      out_ready,
  output word_t     out_result,
  output logic      out_zero,
  output reg_addr_t out_rd,
  output logic      out_reg_write,
  output logic [1:0] occupancy
);

  ex_mem_state_e   r_state, w_state_next;
  ex_mem_payload_t r_main, r_skid;
  ex_mem_payload_t w_main_next, w_skid_next, w_in_payload;
  logic            w_in_fire, w_out_fire;

  // in_ready depends only on the state register, so out_ready never reaches it.
  assign in_ready   = (r_state != StFull);
  assign out_valid  = (r_state != StEmpty);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_in_payload.result    = in_result;
    w_in_payload.zero      = in_zero;
    w_in_payload.rd        = in_rd;
    w_in_payload.reg_write = in_reg_write & (in_rd != '0);
  end

  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush) begin
      w_state_next = StEmpty;
      w_main_next  = '0;
      w_skid_next  = '0;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_next = StOne;
            w_main_next  = w_in_payload;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_next = w_in_payload;
          end else if (w_in_fire) begin
            w_state_next = StFull;
            w_skid_next  = w_in_payload;
          end else if (w_out_fire) begin
            w_state_next = StEmpty;
          end
        end
        StFull: begin
          if (w_out_fire) begin
            w_state_next = StOne;
            w_main_next  = r_skid;
          end
        end
        default: w_state_next = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_result    = r_main.result;
  assign out_zero      = r_main.zero;
  assign out_rd        = r_main.rd;
  assign out_reg_write = r_main.reg_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand-written reset sequences and a
// randomized run checked against a queue-based model of the 2-entry buffer.
module tb_ex_mem_stage;
  import riscv_32i_defs_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  word_t      in_result;
  logic       in_zero;
  reg_addr_t  in_rd;
  logic       in_reg_write;
  logic       out_valid;
  logic       out_ready;
  word_t      out_result;
  logic       out_zero;
  reg_addr_t  out_rd;
  logic       out_reg_write;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  ex_mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        ordy;
    logic [1:0]  occ;
    logic        exp_ir;
    logic        exp_ov;
    logic        chk_pay;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[13];
  ex_mem_payload_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_result    = '0;
    in_zero      = 1'b0;
    in_rd        = '0;
    in_reg_write = 1'b0;
    out_ready    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic ordy);
    in_valid     = 1'b1;
    in_result    = res;
    in_rd        = rd;
    in_reg_write = 1'b1;
    out_ready    = ordy;
    step();
    in_valid     = 1'b0;
  endtask

  initial begin
    // fl iv res rd rw ordy | occ ir ov chk eres erd erw
    vecs[0]  = '{1'b0, 1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h11, 5'd1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h22, 5'd2, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h33, 5'd3, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'h33, 5'd3, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'hA, 5'd4, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 32'hA, 5'd4, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'hB, 5'd5, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'hA, 5'd4, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'hC, 5'd6, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 32'hA, 5'd4, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'hB, 5'd5, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1,
                 32'hDEADBEEF, 5'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'hE, 5'd7, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1,
                 32'hDEADBEEF, 5'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'hF, 5'd8, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 5'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};

    // Reset held with an entry offered: nothing may be captured.
    idle_inputs();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_result = 32'h1234;
    in_rd     = 5'd9;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_result", out_result, 0);
    rst_n = 1'b1;
    idle_inputs();

    for (int i = 0; i < 13; i++) begin
      flush        = vecs[i].fl;
      in_valid     = vecs[i].iv;
      in_result    = vecs[i].res;
      in_rd        = vecs[i].rd;
      in_reg_write = vecs[i].rw;
      out_ready    = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_occ", i), occupancy, vecs[i].occ);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      if (vecs[i].chk_pay) begin
        chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_res);
        chk($sformatf("vec%0d_rd", i), out_rd, vecs[i].exp_rd);
        chk($sformatf("vec%0d_reg_write", i), out_reg_write, vecs[i].exp_rw);
      end
    end
    idle_inputs();

    // Asynchronous reset pulse between edges while FULL.
    push(32'h1, 5'd1, 1'b0);
    push(32'h2, 5'd2, 1'b0);
    chk("ar_pre_occ", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_occ", occupancy, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_result", out_result, 0);
    #1 rst_n = 1'b1;
    step();
    chk("ar_after_occ", occupancy, 0);
    push(32'h5, 5'd3, 1'b1);
    chk("ar_push_valid", out_valid, 1);
    chk("ar_push_result", out_result, 32'h5);
    chk("ar_push_occ", occupancy, 1);
    out_ready = 1'b1;
    step();
    chk("ar_drain_occ", occupancy, 0);

    // Randomized run against an ordered-queue model holding at most two entries.
    q.delete();
    for (int c = 0; c < 600; c++) begin
      ex_mem_payload_t p;
      logic acc, dlv;
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0)
        chk("rnd_payload", {out_result, out_zero, out_rd, out_reg_write}, q[0]);
      flush        = ($urandom_range(0, 19) == 0);
      in_valid     = ($urandom_range(0, 9) < 7);
      in_result    = $urandom;
      in_zero      = $urandom_range(0, 1) == 1;
      in_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_reg_write = $urandom_range(0, 1) == 1;
      out_ready    = ($urandom_range(0, 9) < 5);
      p.result     = in_result;
      p.zero       = in_zero;
      p.rd         = in_rd;
      p.reg_write  = in_reg_write && (in_rd != 5'd0);
      acc = in_valid && (q.size() < 2);
      dlv = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(p);
      end
      step();
    end
    chk("rnd_final_occ", occupancy, q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset (clk, rst_n); these are the only clock and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous discard of all held entries.
REQ-005 in_valid  input  1  ALU-side entry offered.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  32 (word_t)  ALU result.
REQ-008 in_zero  input  1  ALU zero flag.
REQ-009 in_rd  input  5 (reg_addr_t)  destination register.
REQ-010 in_reg_write  input  1  entry writes the register file.
REQ-011 out_valid  output  1  entry presented downstream.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_result, out_zero, out_rd, out_reg_write  output  32/1/5/1  head-entry payload.
REQ-014 occupancy  output  2  entries held (0..2).

Function
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both evaluated at the same rising edge.
REQ-016 The stage SHALL be a 2-entry skid buffer: a main register (head) plus a skid register, with states EMPTY (0), ONE (1) and FULL (2).
REQ-017 EMPTY: in_fire -> ONE, main <= input; otherwise hold.
REQ-018 ONE: in_fire & out_fire -> ONE, main <= input; in_fire only -> FULL, skid <= input; out_fire only -> EMPTY; neither -> hold.
REQ-019 FULL: out_fire -> ONE, main <= skid; otherwise hold; in_valid is ignored.
REQ-020 in_ready SHALL be 1 exactly when state != FULL, driven from the state register with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 exactly when state != EMPTY; out_* payload SHALL always equal the main register.
REQ-022 Latency: an entry accepted into EMPTY at edge N SHALL appear on out_* with out_valid=1 from edge N onward (registered, 1 cycle).
REQ-023 While out_valid=1 and out_ready=0, out_* SHALL remain stable until out_fire.
REQ-024 Entries SHALL leave in acceptance order; none SHALL be lost or duplicated.
REQ-025 At capture, if in_rd == 0 the stored reg_write bit SHALL be 0 (x0 is never written); result, zero and rd are stored unchanged.
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-027 flush=1 SHALL force next state EMPTY and clear both payload registers to 0; it overrides a simultaneous in_fire and out_fire, and the input offered that cycle is dropped.
REQ-028 The payload width SHALL be 39 bits; no arithmetic is performed on it.

Reset
REQ-029 rst_n=0 SHALL immediately force state EMPTY, both payload registers 0, out_valid 0, in_ready 1 and occupancy 0, independent of clk.
REQ-030 Reset asserted mid-transfer SHALL discard all held entries; the first edge after deassertion behaves as EMPTY.

Structure
REQ-031 word_t and reg_addr_t SHALL come from riscv_32i_defs_pkg; the stage-state enum (EMPTY/ONE/FULL) and a packed ex_mem_payload_t struct SHALL be added to riscv_32i_defs_pkg.
REQ-032 The design SHALL be a single module with no sub-modules; the payload registers use the shared struct type.

Verification
REQ-033 Reset: rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_result=0.
REQ-034 Pass-through: out_ready=1, in_valid=1 for three cycles with results 0x11, 0x22, 0x33 -> outputs 0x11, 0x22, 0x33 on consecutive cycles, occupancy constant at 1.
REQ-035 Backpressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_result=0xA held; a third push of 0xC is not accepted; out_ready=1 -> 0xA then 0xB delivered, in_ready returns to 1.
REQ-036 x0 suppression: in_rd=0, in_reg_write=1, result 0xDEADBEEF -> out_reg_write=0, out_rd=0, out_result=0xDEADBEEF.
REQ-037 Flush: FULL state with flush=1 and in_valid=1 on the same edge -> next cycle occupancy=0, out_valid=0, and the offered entry is never output.
REQ-038 Async reset: rst_n pulsed low between clock edges while FULL -> outputs clear before the next edge; the next push of 0x5 outputs 0x5.
